// File: rtl/collision_detector_multi.sv
// N-channel ball/object collision detector: per-channel pulse or level outputs with
// frame cooldown, plus registered per-frame hit summaries and a saturating pulse counter.
module collision_detector_multi #(
  parameter int unsigned              NUM_OBJ         = 8,
  parameter logic [NUM_OBJ-1:0]       EDGE_MASK       = '1,
  parameter int unsigned              COOLDOWN_FRAMES = 0,
  parameter int unsigned              CD_W            = 4,
  parameter int unsigned              COUNT_W         = 8
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic                        draw_ball,
  input  logic [NUM_OBJ-1:0]          drawObj,
  input  logic                        clearCount,
  output logic [NUM_OBJ-1:0]          collision,
  output logic [NUM_OBJ-1:0]          frameHitMask,
  output logic                        anyHit,
  output logic [$clog2(NUM_OBJ)-1:0]  firstHitId,
  output logic                        firstHitValid,
  output logic [COUNT_W-1:0]          hitCount
);

  localparam int unsigned ID_W  = $clog2(NUM_OBJ);
  localparam int unsigned POP_W = $clog2(NUM_OBJ + 1);
  localparam int unsigned SUM_W = ((COUNT_W > POP_W) ? COUNT_W : POP_W) + 1;
  localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({COUNT_W{1'b1}});

  logic [NUM_OBJ-1:0] raw;
  logic [NUM_OBJ-1:0] pulse;
  logic [NUM_OBJ-1:0] hitLatch;
  logic [NUM_OBJ-1:0] blocked;
  logic [NUM_OBJ-1:0] latchEff;
  logic [NUM_OBJ-1:0] blkEff;
  logic [CD_W-1:0]    cd [NUM_OBJ];
  logic [NUM_OBJ-1:0] frameAcc;
  logic [ID_W-1:0]    capId;
  logic               capValid;
  logic [ID_W-1:0]    pulseId;
  logic               pulseFound;
  logic [POP_W-1:0]   pulseCnt;
  logic [SUM_W-1:0]   countSum;
  logic [COUNT_W-1:0] countNext;

  // On the frame-start cycle the latch/suppression state of the new frame is used directly.
  always_comb begin
    raw      = drawObj & {NUM_OBJ{draw_ball}};
    latchEff = startOfFrame ? '0 : hitLatch;
    blkEff   = '0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      blkEff[i] = startOfFrame ? (cd[i] != '0) : blocked[i];
    end
    pulse     = EDGE_MASK & raw & ~latchEff & ~blkEff;
    collision = pulse | (raw & ~EDGE_MASK);
  end

  always_comb begin
    pulseId    = '0;
    pulseFound = 1'b0;
    pulseCnt   = '0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      if (pulse[i] && !pulseFound) begin
        pulseId    = ID_W'(i);
        pulseFound = 1'b1;
      end
      pulseCnt = pulseCnt + POP_W'(pulse[i]);
    end
    countSum  = SUM_W'(hitCount) + SUM_W'(pulseCnt);
    countNext = (countSum > CNT_MAX) ? '1 : countSum[COUNT_W-1:0];
  end

  // A pulse on a frame-start cycle implies cd==0, so blocked needs no pulse override.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hitLatch <= '0;
      blocked  <= '0;
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        cd[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        if (startOfFrame) begin
          blocked[i] <= EDGE_MASK[i] && (cd[i] != '0);
        end
        if (pulse[i]) begin
          hitLatch[i] <= 1'b1;
          cd[i]       <= CD_LOAD;
        end else if (startOfFrame) begin
          hitLatch[i] <= 1'b0;
          if (cd[i] != '0) begin
            cd[i] <= cd[i] - CD_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frameAcc      <= '0;
      capId         <= '0;
      capValid      <= 1'b0;
      frameHitMask  <= '0;
      anyHit        <= 1'b0;
      firstHitId    <= '0;
      firstHitValid <= 1'b0;
    end else if (startOfFrame) begin
      frameHitMask  <= frameAcc;
      anyHit        <= |frameAcc;
      firstHitId    <= capId;
      firstHitValid <= capValid;
      frameAcc      <= collision;
      capId         <= pulseId;
      capValid      <= pulseFound;
    end else begin
      frameAcc <= frameAcc | collision;
      if (!capValid && pulseFound) begin
        capId    <= pulseId;
        capValid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hitCount <= '0;
    end else if (clearCount) begin
      hitCount <= '0;
    end else begin
      hitCount <= countNext;
    end
  end

endmodule

// File: tb/tb_collision_detector_multi.sv
// Bench for collision_detector_multi: directed scenarios plus random traffic, all
// checked every cycle against a frame-number based reference model.
module tb_collision_detector_multi;

  localparam logic [7:0] EDGE = 8'h7F;
  localparam int         CDF  = 2;
  localparam int         CMAX = 7;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, draw_ball, clearCount;
  logic [7:0] drawObj;
  logic [7:0] collision, frameHitMask;
  logic       anyHit, firstHitValid;
  logic [2:0] firstHitId;
  logic [2:0] hitCount;

  collision_detector_multi #(
    .NUM_OBJ(8), .EDGE_MASK(EDGE), .COOLDOWN_FRAMES(CDF), .CD_W(4), .COUNT_W(3)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .draw_ball(draw_ball),
    .drawObj(drawObj), .clearCount(clearCount), .collision(collision),
    .frameHitMask(frameHitMask), .anyHit(anyHit), .firstHitId(firstHitId),
    .firstHitValid(firstHitValid), .hitCount(hitCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: a pulse channel may fire in frame F only if its last pulse was before F-CDF
  int         frameIdx;
  int         lastPulse [8];
  logic [7:0] accMask, mMask, mPulse, mCol;
  logic       mAny, mValid;
  int         capId;
  logic [2:0] mFirst;
  int         mCount;
  logic [7:0] sampledCol;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic modelReset();
    frameIdx = 0;
    for (int i = 0; i < 8; i++) lastPulse[i] = -100;
    accMask = '0; mMask = '0; mAny = 1'b0; mValid = 1'b0; mFirst = '0;
    capId = -1; mCount = 0;
  endtask

  task automatic modelEval(input logic s, input logic b, input logic [7:0] o);
    int curFrame;
    logic [7:0] rawM;
    curFrame = frameIdx + (s ? 1 : 0);
    rawM = b ? o : 8'h00;
    for (int i = 0; i < 8; i++)
      mPulse[i] = EDGE[i] && rawM[i] && (curFrame - lastPulse[i] > CDF);
    mCol = mPulse | (rawM & ~EDGE);
  endtask

  task automatic modelClock(input logic s, input logic c);
    if (s) begin
      frameIdx++;
      mMask   = accMask;
      mAny    = |accMask;
      mValid  = (capId >= 0);
      mFirst  = (capId >= 0) ? 3'(capId) : 3'd0;
      accMask = mCol;
      capId   = lowest(mPulse);
    end else begin
      accMask = accMask | mCol;
      if (capId < 0) capId = lowest(mPulse);
    end
    for (int i = 0; i < 8; i++) if (mPulse[i]) lastPulse[i] = frameIdx;
    if (c) mCount = 0;
    else begin
      mCount = mCount + $countones(mPulse);
      if (mCount > CMAX) mCount = CMAX;
    end
  endtask

  task automatic step(input logic s, input logic b, input logic [7:0] o, input logic c);
    @(negedge clk);
    startOfFrame = s; draw_ball = b; drawObj = o; clearCount = c;
    #1;
    modelEval(s, b, o);
    sampledCol = collision;
    chk("collision", 32'(collision), 32'(mCol));
    chk("frameHitMask", 32'(frameHitMask), 32'(mMask));
    chk("anyHit", 32'(anyHit), 32'(mAny));
    chk("firstHitId", 32'(firstHitId), 32'(mFirst));
    chk("firstHitValid", 32'(firstHitValid), 32'(mValid));
    chk("hitCount", 32'(hitCount), 32'(mCount));
    @(posedge clk);
    modelClock(s, c);
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_collision"}, 32'(collision), 32'h0);
    chk({tag, "_mask"}, 32'(frameHitMask), 32'h0);
    chk({tag, "_any"}, 32'(anyHit), 32'h0);
    chk({tag, "_firstId"}, 32'(firstHitId), 32'h0);
    chk({tag, "_firstValid"}, 32'(firstHitValid), 32'h0);
    chk({tag, "_count"}, 32'(hitCount), 32'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    startOfFrame = 1'b0; draw_ball = 1'b0; drawObj = '0; clearCount = 1'b0;
    #1 resetN = 1'b0;
    #1 checkAllZero("reset");
    modelReset();
    @(negedge clk);
    #2 resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; draw_ball = 1'b0; drawObj = '0; clearCount = 1'b0;
    modelReset();
    #1 checkAllZero("por");
    @(negedge clk);
    @(negedge clk);
    #2 resetN = 1'b1;

    // single channel held 5 cycles mid-frame: one pulse
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h04, 0);
      chk("single_col", 32'(sampledCol), (i == 0) ? 32'h04 : 32'h0);
    end
    step(1, 0, 8'h00, 0);
    #1;
    chk("single_mask", 32'(frameHitMask), 32'h04);
    chk("single_any", 32'(anyHit), 32'h1);
    chk("single_first", 32'(firstHitId), 32'h2);

    // simultaneous hits on the first cycle of a frame
    step(1, 1, 8'h22, 0);
    chk("simul_col", 32'(sampledCol), 32'h22);
    step(0, 0, 8'h00, 0);
    #1 chk("simul_count", 32'(hitCount), 32'h3);
    step(1, 0, 8'h00, 0);
    #1;
    chk("simul_first", 32'(firstHitId), 32'h1);
    chk("simul_valid", 32'(firstHitValid), 32'h1);
    chk("simul_mask", 32'(frameHitMask), 32'h22);

    // cooldown of 2 frames on channel 0
    for (int f = 0; f < 5; f++) begin
      step(1, 1, 8'h01, 0);
      chk("cool_sof_col", 32'(sampledCol[0]), (f == 0 || f == 3) ? 32'h1 : 32'h0);
      step(0, 1, 8'h01, 0);
      chk("cool_mid_col", 32'(sampledCol[0]), 32'h0);
    end

    // hit on the frame-start cycle with level channel 7
    step(1, 1, 8'h88, 0);
    chk("edge_col", 32'(sampledCol), 32'h88);
    #1 chk("edge_oldmask", 32'(frameHitMask), 32'h00);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 8'h80, 0);
      chk("level_col", 32'(sampledCol), 32'h80);
    end
    step(1, 0, 8'h00, 0);
    #1;
    chk("edge_newmask", 32'(frameHitMask), 32'h88);
    chk("level_count", 32'(hitCount), 32'h6);

    // saturation then clear with a concurrent pulse
    step(1, 1, 8'h70, 0);
    #1 chk("sat_count", 32'(hitCount), 32'h7);
    step(1, 1, 8'h04, 0);
    #1 chk("sat_hold", 32'(hitCount), 32'h7);
    step(1, 1, 8'h02, 1);
    chk("clr_col", 32'(sampledCol), 32'h02);
    #1 chk("clr_count", 32'(hitCount), 32'h0);

    // reset mid-frame with cooldown loaded
    step(1, 1, 8'h01, 0);
    chk("pre_rst_col", 32'(sampledCol), 32'h01);
    doReset();
    step(0, 1, 8'h01, 0);
    chk("post_rst_col", 32'(sampledCol), 32'h01);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) doReset();
      else step(($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
                8'($urandom) & 8'($urandom), ($urandom_range(0, 63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_detector_multi.md
# collision_detector_multi

Parametrised N-channel collision detector for the pinball video pipeline. It compares the ball draw request against N object draw requests per pixel. For each channel it emits either a once-per-frame collision pulse or a raw level, with optional multi-frame cooldown. It also produces registered per-frame summaries (hit mask, first-hit index, saturating hit counter) for the game-logic and scoring blocks downstream of the object drawers.

## Interface
- NUM_OBJ, 8: number of object channels (≥2).
- EDGE_MASK, all ones (NUM_OBJ bits): bit i=1 selects pulse mode for channel i; bit i=0 selects level mode.
- COOLDOWN_FRAMES, 0: whole frames suppressed after a pulse-mode hit (0..2^CD_W-1).
- CD_W, 4: cooldown counter width.
- COUNT_W, 8: hit counter width.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle strobe; this cycle is the first cycle of the new frame.
- draw_ball  in  1  ball pixel request.
- drawObj  in  NUM_OBJ  object pixel requests, bit i = channel i.
- clearCount  in  1  synchronous clear of hitCount.
- collision  out  NUM_OBJ  per-channel collision, combinational, zero latency.
- frameHitMask  out  NUM_OBJ  registered; channels hit during the previous frame.
- anyHit  out  1  registered; OR of frameHitMask.
- firstHitId  out  $clog2(NUM_OBJ)  registered; first pulse-mode channel hit in the previous frame.
- firstHitValid  out  1  registered; firstHitId is meaningful.
- hitCount  out  COUNT_W  registered; saturating count of pulse-mode pulses.

## Operation
- raw[i] = draw_ball && drawObj[i].
- Level channel (EDGE_MASK[i]=0):
  - collision[i] = raw[i].
  - No latch, no cooldown, not counted, excluded from firstHit.
  - Does contribute to frameHitMask.
- Pulse channel state: hitLatch[i] (hit this frame), cd[i] (cooldown counter), blocked[i] (frame suppressed).
- Effective values for pulse channel i:
  - latchEff = startOfFrame ? 0 : hitLatch[i].
  - blkEff = startOfFrame ? (cd[i]!=0) : blocked[i].
- collision[i] = raw[i] && !latchEff && !blkEff.
- On a pulse-mode pulse: hitLatch[i]<=1 and cd[i]<=COOLDOWN_FRAMES. The load overrides a same-cycle decrement.
- On startOfFrame with no pulse on channel i:
  - hitLatch[i]<=0.
  - blocked[i]<=(cd[i]!=0).
  - cd[i]<=cd[i]-1 if nonzero.
- Result: a pulse in frame F suppresses frames F+1..F+COOLDOWN_FRAMES entirely; the next pulse is possible in frame F+COOLDOWN_FRAMES+1.
- frameAcc[i] records raw hits in frame: pulse channels record pulses; level channels record raw[i]. It is cleared at startOfFrame, then OR-ed with the startOfFrame-cycle hit.
- At startOfFrame, frameHitMask<=frameAcc and anyHit<=|frameAcc. The startOfFrame cycle's own hits belong to the new frame.
- firstHit capture:
  - On the first cycle of a frame with any pulse, capture the lowest index among simultaneous pulses and set capValid.
  - At startOfFrame, firstHitId<=capId and firstHitValid<=capValid. The capture then reseeds from that cycle's pulses, or clears.
- hitCount:
  - Adds the popcount of pulse-mode collision bits each cycle.
  - Saturates at 2^COUNT_W-1.
  - clearCount has priority: the counter becomes 0 and that cycle's pulses are discarded.

## Timing
- collision: same cycle as inputs, purely combinational.
- frameHitMask, anyHit, firstHitId, firstHitValid:
  - Update on the clock edge ending the startOfFrame cycle.
  - Hold for the whole frame.
- hitCount: visible one cycle after the pulse.
- Reset (async, any time including mid-frame):
  - All outputs and registers go to 0: hitLatch, cd, blocked, frameAcc, capture, frameHitMask, anyHit, firstHitId, firstHitValid, hitCount.
  - The first frame after reset is unsuppressed.
- No startOfFrame ever: latches stay set, so each pulse channel fires at most once; cooldown does not advance.
- Back-to-back startOfFrame cycles are legal; each counts as a frame boundary.

## Test plan
- Single channel, COOLDOWN_FRAMES=0:
  - Stimulus: raw[2] high for 5 consecutive cycles mid-frame.
  - Response: collision[2] high only in the first cycle; next frame frameHitMask=8'h04, anyHit=1.
- Cooldown, COOLDOWN_FRAMES=2:
  - Stimulus: raw[0] held in every frame.
  - Response: pulses in frames 0 and 3 only; cd reads 2→1→0.
- Simultaneous hits:
  - Stimulus: raw[5] and raw[1] in the same cycle, first of the frame.
  - Response: two pulses; hitCount +2; next frame firstHitId=1, firstHitValid=1.
- Boundary and mode:
  - Stimulus: hit on the startOfFrame cycle, with channel 7 in level mode (EDGE_MASK[7]=0) held 3 cycles.
  - Response: the startOfFrame-cycle hit pulses, is counted in the new frame's mask, and not in the just-loaded one. collision[7] is high for 3 cycles; hitCount is unchanged by channel 7.
- Saturation and clear, COUNT_W=3:
  - Stimulus: 9 pulses, then clearCount asserted together with a pulse.
  - Response: hitCount sticks at 7, then reads 0.
- Reset mid-frame:
  - Stimulus: assert resetN low after a hit with cd=2.
  - Response: all outputs 0 immediately; after release, a hit in the next cycle pulses.
